// File: rtl/stft_ram_reader.sv
// Spectrogram RAM reader: scans stored magnitudes (bins high to low, FFTs oldest to
// newest) and streams 4-bit pixels on valid/ready with row and frame markers.
module stft_ram_reader #(
  parameter int FFT_SIZE      = 256,
  parameter int NO_FFTS       = 50,
  parameter int ADDRESS_WIDTH = 12,
  parameter int NO_BANKS      = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [$clog2(NO_FFTS)-1:0] oldest_fft_idx,
  input  logic                       frame_start,
  input  logic [4*NO_BANKS-1:0]      rd_data,
  output logic                       rd_en,
  output logic [NO_BANKS-1:0]        bank_rd,
  output logic [ADDRESS_WIDTH-1:0]   addr_rd,
  output logic [3:0]                 pix_data,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic                       pix_eol,
  output logic                       pix_last,
  output logic                       busy
);

  localparam int BINS   = FFT_SIZE / 2;
  localparam int SLOT_W = $clog2(NO_FFTS);
  localparam int BIN_W  = $clog2(BINS);
  localparam int LIN_W  = $clog2(NO_FFTS * BINS);
  localparam int BUF_D  = 3;

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DRAIN = 2'd2} state_t;

  state_t                   state_r;
  logic [SLOT_W-1:0]        snap_r, slot_r, col_r;
  logic [BIN_W-1:0]         bin_r;
  logic                     rd_en_r, busy_r, iss_eol_r, iss_last_r;
  logic [NO_BANKS-1:0]      bank_rd_r, pend_bank_r;
  logic [ADDRESS_WIDTH-1:0] addr_rd_r;
  logic                     pend_r, pend_eol_r, pend_last_r;
  logic [5:0]               buf_r [BUF_D];
  logic [1:0]               cnt_r;
  logic                     pix_valid_r;

  logic                     pop_s, issue_s, eol_s, last_s;
  logic [SLOT_W-1:0]        pos_slot_s, pos_col_s, snap_s, next_slot_s;
  logic [BIN_W-1:0]         pos_bin_s;
  logic [LIN_W-1:0]         lin_s;
  logic [3:0]               field_s;
  logic [5:0]               ent_s [BUF_D];
  logic [1:0]               cnt_pop_s, cnt_s;

  assign pop_s = pix_valid_r & pix_ready;

  // Scan position of the next read, its address, and whether it may issue this cycle
  always_comb begin
    pos_slot_s = slot_r;
    pos_col_s  = col_r;
    pos_bin_s  = bin_r;
    snap_s     = snap_r;
    issue_s    = 1'b0;
    case (state_r)
      IDLE: begin
        pos_slot_s = oldest_fft_idx;
        pos_col_s  = '0;
        pos_bin_s  = BIN_W'(BINS - 1);
        snap_s     = oldest_fft_idx;
        issue_s    = frame_start;
      end
      SCAN:    issue_s = ({1'b0, cnt_r} + {2'b00, rd_en_r}) < (3'd2 + {2'b00, pop_s});
      default: issue_s = 1'b0;
    endcase
    lin_s  = LIN_W'(pos_slot_s) * LIN_W'(BINS) + LIN_W'(pos_bin_s);
    eol_s  = (pos_col_s == SLOT_W'(NO_FFTS - 1));
    last_s = eol_s && (pos_bin_s == '0);
    // Slots run newest-ward by decrementing; each row restarts at the captured oldest slot
    if (eol_s) begin
      next_slot_s = snap_s;
    end else if (pos_slot_s == '0) begin
      next_slot_s = SLOT_W'(NO_FFTS - 1);
    end else begin
      next_slot_s = pos_slot_s - SLOT_W'(1);
    end
  end

  // Frame state machine, scan counters and the read request / response pipeline
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      snap_r      <= '0;
      slot_r      <= '0;
      col_r       <= '0;
      bin_r       <= '0;
      rd_en_r     <= 1'b0;
      bank_rd_r   <= '0;
      addr_rd_r   <= '0;
      iss_eol_r   <= 1'b0;
      iss_last_r  <= 1'b0;
      pend_r      <= 1'b0;
      pend_bank_r <= '0;
      pend_eol_r  <= 1'b0;
      pend_last_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      rd_en_r     <= issue_s;
      pend_r      <= rd_en_r;
      pend_bank_r <= bank_rd_r;
      pend_eol_r  <= iss_eol_r;
      pend_last_r <= iss_last_r;
      if (issue_s) begin
        bank_rd_r  <= NO_BANKS'(1) << (lin_s >> ADDRESS_WIDTH);
        addr_rd_r  <= ADDRESS_WIDTH'(lin_s);
        iss_eol_r  <= eol_s;
        iss_last_r <= last_s;
        slot_r     <= next_slot_s;
        col_r      <= eol_s ? '0 : pos_col_s + SLOT_W'(1);
        bin_r      <= eol_s ? pos_bin_s - BIN_W'(1) : pos_bin_s;
      end
      case (state_r)
        IDLE: begin
          if (frame_start) begin
            snap_r  <= oldest_fft_idx;
            busy_r  <= 1'b1;
            state_r <= last_s ? DRAIN : SCAN;
          end
        end
        SCAN: begin
          if (issue_s && last_s) state_r <= DRAIN;
        end
        DRAIN: begin
          if (pop_s && buf_r[0][5]) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Picks the returned nibble of the bank that was addressed one cycle earlier
  always_comb begin
    field_s = 4'd0;
    for (int b = 0; b < NO_BANKS; b++) begin
      if (pend_bank_r[b]) field_s = field_s | rd_data[4*b +: 4];
      else                field_s = field_s;
    end
  end

  // Next buffer contents: shift out the head on accept, append the landing read.
  // The issue rule lets one read land on a full pair, hence the spare third slot.
  always_comb begin
    ent_s = buf_r;
    if (pop_s) begin
      for (int i = 0; i < BUF_D - 1; i++) ent_s[i] = buf_r[i+1];
      ent_s[BUF_D-1] = 6'd0;
      cnt_pop_s      = cnt_r - 2'd1;
    end else begin
      cnt_pop_s = cnt_r;
    end
    if (pend_r) begin
      case (cnt_pop_s)
        2'd0:    ent_s[0] = {pend_last_r, pend_eol_r, field_s};
        2'd1:    ent_s[1] = {pend_last_r, pend_eol_r, field_s};
        2'd2:    ent_s[2] = {pend_last_r, pend_eol_r, field_s};
        default: ent_s[0] = ent_s[0];
      endcase
      cnt_s = cnt_pop_s + 2'd1;
    end else begin
      cnt_s = cnt_pop_s;
    end
  end

  // Output buffer registers; entry 0 drives the pixel outputs directly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BUF_D; i++) buf_r[i] <= 6'd0;
      cnt_r       <= 2'd0;
      pix_valid_r <= 1'b0;
    end else begin
      buf_r       <= ent_s;
      cnt_r       <= cnt_s;
      pix_valid_r <= (cnt_s != 2'd0);
    end
  end

  assign rd_en     = rd_en_r;
  assign bank_rd   = bank_rd_r;
  assign addr_rd   = addr_rd_r;
  assign pix_data  = buf_r[0][3:0];
  assign pix_eol   = buf_r[0][4];
  assign pix_last  = buf_r[0][5];
  assign pix_valid = pix_valid_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_stft_ram_reader.sv
// Bench for stft_ram_reader: synchronous two-bank RAM model holding (slot+bin)&15,
// a per-frame reference scan order, spot-vector table and hand-built corner sequences.
module tb_stft_ram_reader;

  localparam int NPIX = 6400;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  oldest_fft_idx = 6'd0;
  logic        frame_start = 1'b0;
  logic [7:0]  rd_data = 8'd0;
  logic        rd_en;
  logic [1:0]  bank_rd;
  logic [11:0] addr_rd;
  logic [3:0]  pix_data;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic        pix_eol;
  logic        pix_last;
  logic        busy;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  int          exp_lin  [NPIX];
  logic [5:0]  exp_px   [NPIX];
  logic [1:0]  got_bank [NPIX];
  logic [11:0] got_addr [NPIX];
  logic [5:0]  got_px   [NPIX];

  typedef struct {
    int          snap;
    int          idx;
    logic [1:0]  bank;
    logic [11:0] addr;
    logic [1:0]  flags;  // {last, eol} of the pixel at idx
  } vec_t;
  vec_t vecs [9];

  stft_ram_reader dut (
    .clk(clk), .reset(reset), .oldest_fft_idx(oldest_fft_idx), .frame_start(frame_start),
    .rd_data(rd_data), .rd_en(rd_en), .bank_rd(bank_rd), .addr_rd(addr_rd),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_eol(pix_eol), .pix_last(pix_last), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Unselected bank returns the complement so a wrong bank pick is visible
  function automatic logic [7:0] ram_word(input logic [1:0] b, input logic [11:0] a);
    int l;
    logic [3:0] v;
    l = (b == 2'b10 ? 4096 : 0) + int'(a);
    v = 4'(((l / 128) + (l % 128)) % 16);
    ram_word = {b[1] ? v : ~v, b[0] ? v : ~v};
  endfunction

  always @(posedge clk) begin
    if (rd_en) rd_data <= ram_word(bank_rd, addr_rd);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  function automatic void build_model(input int snap);
    int k, slot, bin;
    for (int r = 0; r < 128; r++) begin
      for (int c = 0; c < 50; c++) begin
        k    = r * 50 + c;
        slot = (snap + 50 - c) % 50;
        bin  = 127 - r;
        exp_lin[k] = slot * 128 + bin;
        exp_px[k]  = {(r == 127 && c == 49) ? 1'b1 : 1'b0, (c == 49) ? 1'b1 : 1'b0,
                      4'((slot + bin) % 16)};
      end
    end
  endfunction

  task automatic check_table(input int snap);
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].snap == snap) begin
        check("tbl_read", {got_bank[vecs[i].idx], got_addr[vecs[i].idx]}, {vecs[i].bank, vecs[i].addr});
        check("tbl_flags", got_px[vecs[i].idx][5:4], vecs[i].flags);
      end
    end
  endtask

  // mode 0: ready high; 1: random ready ~30%; 2: ready high with ignored requests
  task automatic run_frame(input int snap, input int mode);
    int t_req, first_valid, last_acc, gaps, bsy_gaps, n_rd, n_px, guard, stab_err, wl;
    bit seen, done, hold;
    logic [5:0] held_px;
    build_model(snap);
    n_rd = 0; n_px = 0; gaps = 0; bsy_gaps = 0; stab_err = 0; guard = 0;
    seen = 1'b0; done = 1'b0; hold = 1'b0; held_px = 6'd0;
    first_valid = -1; last_acc = -1;
    @(negedge clk);
    oldest_fft_idx = 6'(snap);
    frame_start    = 1'b1;
    pix_ready      = 1'b1;
    t_req          = cyc + 1;
    while (!done && guard < 40000) begin
      @(negedge clk);
      guard++;
      frame_start = 1'b0;
      if (mode == 2 && guard == 100) frame_start = 1'b1;
      if (mode == 2 && guard == 150) oldest_fft_idx = 6'd17;
      if (!busy) bsy_gaps++;
      if (rd_en) begin
        if (n_rd < NPIX) begin
          wl = exp_lin[n_rd];
          check("read_addr", {bank_rd, addr_rd}, {(wl >= 4096) ? 2'b10 : 2'b01, 12'(wl % 4096)});
          got_bank[n_rd] = bank_rd;
          got_addr[n_rd] = addr_rd;
        end
        n_rd++;
      end
      if (hold && (!pix_valid || {pix_last, pix_eol, pix_data} != held_px)) stab_err++;
      pix_ready = (mode == 1) ? ($urandom_range(0, 9) < 3) : 1'b1;
      if (pix_valid) begin
        if (!seen) first_valid = cyc;
        seen = 1'b1;
      end else if (seen) begin
        gaps++;
      end
      if (pix_valid && pix_ready) begin
        if (n_px < NPIX) begin
          check("pixel", {pix_last, pix_eol, pix_data}, exp_px[n_px]);
          got_px[n_px] = {pix_last, pix_eol, pix_data};
        end
        n_px++;
        if (pix_last) begin
          done     = 1'b1;
          last_acc = cyc + 1;
          if (mode == 2) frame_start = 1'b1;
        end
      end
      hold    = pix_valid && !pix_ready;
      held_px = {pix_last, pix_eol, pix_data};
    end
    check("frame_done", done, 1);
    check("read_count", n_rd, NPIX);
    check("pixel_count", n_px, NPIX);
    check("busy_gaps", bsy_gaps, 0);
    check("hold_stable", stab_err, 0);
    if (mode != 1) begin
      check("first_valid_latency", first_valid - t_req, 2);
      check("frame_cycles", last_acc - t_req + 1, 6403);
      check("bubbles", gaps, 0);
    end
    @(negedge clk);
    check("busy_after_last", busy, 0);
  endtask

  initial begin
    int viol;
    vecs[0] = '{0,    0, 2'b01, 12'd127,  2'b00};
    vecs[1] = '{0,    1, 2'b10, 12'd2303, 2'b00};
    vecs[2] = '{0,   49, 2'b01, 12'd255,  2'b01};
    vecs[3] = '{0,   50, 2'b01, 12'd126,  2'b00};
    vecs[4] = '{0, 6399, 2'b01, 12'd128,  2'b11};
    vecs[5] = '{32,   0, 2'b10, 12'd127,  2'b00};
    vecs[6] = '{32,  32, 2'b01, 12'd127,  2'b00};
    vecs[7] = '{32,  33, 2'b10, 12'd2303, 2'b00};
    vecs[8] = '{32, 6350, 2'b10, 12'd0,   2'b00};

    #1 reset = 1'b1;
    #1 check("reset_outputs", {rd_en, bank_rd, addr_rd, pix_data, pix_valid, pix_eol, pix_last, busy}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    run_frame(0, 0);
    check_table(0);
    run_frame(32, 0);
    check_table(32);
    run_frame(0, 1);
    run_frame(5, 2);

    // frame_start is still high: a request the cycle after the final accept starts a frame
    @(negedge clk);
    frame_start = 1'b0;
    check("restart_next_cycle", busy, 1);
    repeat (300) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("reset_mid_frame", {rd_en, bank_rd, addr_rd, pix_data, pix_valid, pix_eol, pix_last, busy}, 0);
    @(negedge clk);
    reset = 1'b0;
    viol = 0;
    repeat (30) begin
      @(negedge clk);
      if (pix_valid || rd_en || busy) viol++;
    end
    check("idle_after_reset", viol, 0);

    run_frame(49, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
